approx_recursive_mult_pipe: RTL

Parametrised, pipelined recursive multiplier for the Gaussian-smoothing datapath and later demos. A WIDTH x WIDTH product is built from a grid of 4x4 tiles. Low-order tiles are replaced by the N1 or N2 approximate 4x4 cores, selected per transaction by a mode input. The block has a valid/ready handshake on both sides and a fixed 3-cycle latency, so it can stream pixel/kernel pairs under backpressure.

---
 rtl/approx_recursive_mult_pipe_pkg.sv | 20 ++
 rtl/approx_recursive_mult_pipe_if.sv | 25 ++
 rtl/approx_recursive_mult_pipe_tile.sv | 64 ++++++
 rtl/approx_recursive_mult_pipe.sv | 96 +++++++++
 4 files changed

// File: rtl/approx_recursive_mult_pipe_pkg.sv
// Shared types and helpers for the recursive 4x4-tile multiplier.
// Covers the mode encoding, the tile width and the per-tile approximation rule.
package approx_mult_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_N1    = 2'd1,
        MODE_N2    = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int TILE_W = 4;

    // Only the low-order diagonals are approximated, and only in the N1/N2 modes.
    function automatic logic tile_is_approx(input int i, input int j, input mode_e mode,
                                            input int approx_diag);
        return ((mode == MODE_N1) || (mode == MODE_N2)) && ((i + j) < approx_diag);
    endfunction

endpackage

// File: rtl/approx_recursive_mult_pipe_if.sv
// Operand/result handshake bundle for approx_recursive_mult_pipe.
// The master drives operands and the result-ready signal; the slave is the multiplier.
interface approx_recursive_mult_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [1:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_y;
    logic [1:0]           out_mode;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_y, out_mode
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_y, out_mode
    );
endinterface

// File: rtl/approx_recursive_mult_pipe_tile.sv
// 4x4 multiplier tile with selectable exact, N1 or N2 approximate core.
// Purely combinational; an unrecognised select falls back to the exact core.
module mult4x4_tile
    import approx_mult_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  mode_e      sel,
    output logic [7:0] y
);

    logic [3:0][3:0] p;
    logic [7:0]      exact_y;
    logic [7:0]      n1_y;
    logic [7:0]      n2_y;
    logic [4:0]      low_y;
    logic            c;

    // p[i][j] = a[i] & b[j]
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            for (genvar gj = 0; gj < 4; gj++) begin : g_col
                assign p[gi][gj] = a[gi] & b[gj];
            end
        end
    endgenerate

    assign exact_y = {4'b0000, a} * {4'b0000, b};

    // Columns 1..4 collapse to an OR of their partial products in both approximate cores.
    assign low_y = {
        p[1][3] | p[2][2] | p[3][1],
        p[0][3] | p[1][2] | p[2][1] | p[3][0],
        p[0][2] | p[1][1] | p[2][0],
        p[0][1] | p[1][0],
        p[0][0]
    };

    assign c = p[2][2] & (p[1][3] | p[3][1]);

    assign n2_y = {
        p[3][3] & p[2][2],
        p[3][3] & ~p[2][2],
        p[3][2] | p[2][3],
        low_y
    };

    assign n1_y = {
        p[2][2] & p[3][3],
        (p[3][3] & ~p[2][2]) | (~p[3][3] & p[2][2] & (p[3][1] | p[1][3])),
        p[3][2] ^ p[2][3] ^ c,
        low_y
    };

    always_comb begin
        y = exact_y;
        case (sel)
            MODE_N1: y = n1_y;
            MODE_N2: y = n2_y;
            default: y = exact_y;
        endcase
    end

endmodule

// File: rtl/approx_recursive_mult_pipe.sv
// Three-stage recursive WIDTH x WIDTH multiplier built from 4x4 tiles, low tiles optionally approximate.
// One global enable stalls every stage together, so a result is held until the consumer takes it.
module approx_recursive_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_DIAG = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    approx_recursive_mult_pipe_if.slave  bus
);

    localparam int NT     = WIDTH / TILE_W;
    localparam int NTILES = NT * NT;
    localparam int YW     = 2 * WIDTH;

    logic             en;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    mode_e            s1_mode_reg;

    logic             s2_valid_reg;
    mode_e            s2_mode_reg;
    logic [7:0]       s2_tile_reg [NTILES];
    logic [7:0]       tile_next   [NTILES];

    logic             out_valid_reg;
    logic [YW-1:0]    out_y_reg;
    mode_e            out_mode_reg;
    logic [YW-1:0]    sum_next;

    assign en           = ~out_valid_reg | bus.out_ready;
    assign bus.in_ready = en;

    // Tile (i,j) multiplies nibble i of a with nibble j of b.
    generate
        for (genvar gi = 0; gi < NT; gi++) begin : g_tile_row
            for (genvar gj = 0; gj < NT; gj++) begin : g_tile_col
                mode_e core_sel;
                assign core_sel = tile_is_approx(gi, gj, s1_mode_reg, APPROX_DIAG) ?
                                  s1_mode_reg : MODE_EXACT;
                mult4x4_tile u_tile (
                    .a   (s1_a_reg[gi*TILE_W +: TILE_W]),
                    .b   (s1_b_reg[gj*TILE_W +: TILE_W]),
                    .sel (core_sel),
                    .y   (tile_next[gi*NT + gj])
                );
            end
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NT; i++) begin
            for (int j = 0; j < NT; j++) begin
                sum_next = sum_next + (YW'(s2_tile_reg[i*NT + j]) << (TILE_W * (i + j)));
            end
        end
    end

    // Control and output state: cleared by reset so in-flight work is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_mode_reg  <= MODE_EXACT;
        end else if (en) begin
            s1_valid_reg  <= bus.in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            out_y_reg     <= sum_next;
            out_mode_reg  <= s2_mode_reg;
        end
    end

    // Datapath registers need no reset; their contents only matter behind a valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_a_reg    <= bus.in_a;
            s1_b_reg    <= bus.in_b;
            s1_mode_reg <= mode_e'(bus.in_mode);
            s2_mode_reg <= s1_mode_reg;
            s2_tile_reg <= tile_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_y     = out_y_reg;
    assign bus.out_mode  = out_mode_reg;

endmodule
